untilting_registers: RTL

UNTILTING_REGISTERS -- requirements
Module: untilting_registers

---
 rtl/untilting_registers_if.sv | 19 +
 rtl/untilting_registers.sv | 108 ++++++++++
 2 files changed

// File: rtl/untilting_registers_if.sv
// rtl/untilting_registers_if.sv - skewed-in / aligned-out lane bundle for untilting_registers
interface untilting_registers_if #(
  parameter int wl = 8
);
  logic [wl-1:0] D0_in, D1_in, D2_in, D3_in, D4_in, D5_in, D6_in, D7_in;
  logic [7:0]    V_in;
  logic [wl-1:0] D0_out, D1_out, D2_out, D3_out, D4_out, D5_out, D6_out, D7_out;
  logic          V_out;

  modport master (
    output D0_in, D1_in, D2_in, D3_in, D4_in, D5_in, D6_in, D7_in, V_in,
    input  D0_out, D1_out, D2_out, D3_out, D4_out, D5_out, D6_out, D7_out, V_out
  );

  modport slave (
    input  D0_in, D1_in, D2_in, D3_in, D4_in, D5_in, D6_in, D7_in, V_in,
    output D0_out, D1_out, D2_out, D3_out, D4_out, D5_out, D6_out, D7_out, V_out
  );
endinterface

// File: rtl/untilting_registers.sv
// rtl/untilting_registers.sv - 8-lane de-skew triangle; UNTILT_ZERO_INVALID_EN zeroes data when V_out=0
module untilting_registers #(
  parameter int wl = 8,
  parameter int CW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  untilting_registers_if.slave  lanes,
  output logic                  skew_err,
  output logic [CW-1:0]         word_cnt
);

  logic [wl-1:0] d_in  [8];
  logic [wl-1:0] d_al  [8];
  logic [wl-1:0] d_out [8];
  logic [7:0]    av;
  logic          v_out;
  logic          mismatch;
  logic [2:0]    settle_cnt;
  logic          armed;

  assign d_in[0] = lanes.D0_in;
  assign d_in[1] = lanes.D1_in;
  assign d_in[2] = lanes.D2_in;
  assign d_in[3] = lanes.D3_in;
  assign d_in[4] = lanes.D4_in;
  assign d_in[5] = lanes.D5_in;
  assign d_in[6] = lanes.D6_in;
  assign d_in[7] = lanes.D7_in;

  // Lane i runs through 7-i stages so every lane of a wavefront lines up with lane 7.
  for (genvar gi = 0; gi < 7; gi++) begin : g_lane
    localparam int DEPTH = 7 - gi;
    logic [wl-1:0]    sr [DEPTH];
    logic [DEPTH-1:0] vsr;

    // Free-running shift of lane data and its valid bit, no stall.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
        vsr <= '0;
      end else begin
        sr[0]  <= d_in[gi];
        vsr[0] <= lanes.V_in[gi];
        for (int k = 1; k < DEPTH; k++) begin
          sr[k]  <= sr[k-1];
          vsr[k] <= vsr[k-1];
        end
      end
    end

    assign d_al[gi] = sr[DEPTH-1];
    assign av[gi]   = vsr[DEPTH-1];
  end

  assign d_al[7] = d_in[7];
  assign av[7]   = lanes.V_in[7];

  assign v_out    = &av;
  assign mismatch = (|av) & ~(&av);

  // Lanes still arriving after reset belong to discarded wavefronts; the error
  // check stays off until the first post-reset lane-0 word reaches alignment.
  assign armed = (settle_cnt == 3'd7);

  // Count edges since reset release, saturating once the chains are refilled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        settle_cnt <= '0;
    else if (!armed) settle_cnt <= settle_cnt + 3'd1;
  end

  // Aligned-word counter and sticky skew flag; clr wins over both updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
      skew_err <= 1'b0;
    end else if (clr) begin
      word_cnt <= '0;
      skew_err <= 1'b0;
    end else begin
      if (v_out)             word_cnt <= word_cnt + 1'b1;
      if (mismatch && armed) skew_err <= 1'b1;
    end
  end

  // Present aligned data, optionally blanked outside complete wavefronts.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
`ifdef UNTILT_ZERO_INVALID_EN
      d_out[i] = v_out ? d_al[i] : '0;
`else
      d_out[i] = d_al[i];
`endif
    end
  end

  assign lanes.D0_out = d_out[0];
  assign lanes.D1_out = d_out[1];
  assign lanes.D2_out = d_out[2];
  assign lanes.D3_out = d_out[3];
  assign lanes.D4_out = d_out[4];
  assign lanes.D5_out = d_out[5];
  assign lanes.D6_out = d_out[6];
  assign lanes.D7_out = d_out[7];
  assign lanes.V_out  = v_out;

endmodule
